// File: rtl/matrix_pkg.sv
// Shared constants, sender state encoding and dimension clamp for the result TX path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: MAX_DIM, ELEM_W, BYTES_PER_ELEM, RESULT_W, sender_state_t, eff_dim().
package matrix_pkg;

  localparam int MAX_DIM        = 3;
  localparam int ELEM_W         = 16;
  localparam int BYTES_PER_ELEM = ELEM_W / 8;
  localparam int RESULT_W       = MAX_DIM * MAX_DIM * ELEM_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    NEXT    = 3'd5,
    FINISH  = 3'd6
  } sender_state_t;

  // Requested size clamped to the physical matrix; 0 stays 0 (nothing to send).
  function automatic logic [3:0] eff_dim(input logic [3:0] size, input int max_dim);
    if (size > 4'(max_dim)) return 4'(max_dim);
    return size;
  endfunction

endpackage

// File: rtl/result_sender_if.sv
// Bundles the Calculator-side request and the uart_tx byte handshake of result_sender.
// Latency: n/a (wires only).
// Backpressure: tx_busy from uart_tx holds off tx_start.
// Ports: start/size/result in, busy/done out, tx_data/tx_start out, tx_busy in (sender view = master).
interface result_sender_if
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int ELEM_W  = matrix_pkg::ELEM_W
);
  logic                              start;
  logic [3:0]                        size;
  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] result;
  logic                              busy;
  logic                              done;
  logic [7:0]                        tx_data;
  logic                              tx_start;
  logic                              tx_busy;

  // master: the sender itself
  modport master (
    input  start, size, result, tx_busy,
    output busy, done, tx_data, tx_start
  );

  // slave: whatever drives the request and models uart_tx
  modport slave (
    output start, size, result, tx_busy,
    input  busy, done, tx_data, tx_start
  );
endinterface

// File: rtl/result_byte_mux.sv
// Picks one byte of the snapshotted result matrix by (row, col, byte index).
// Latency: combinational.
// Backpressure: none.
// Ports: snapshot, row, col, byte_idx in; byte_out out.
module result_byte_mux #(
  parameter int MAX_DIM = 3,
  parameter int ELEM_W  = 16
) (
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] snapshot,
  input  logic [3:0]                        row,
  input  logic [3:0]                        col,
  input  logic [3:0]                        byte_idx,
  output logic [7:0]                        byte_out
);

  logic [31:0] pos;

  // Storage is row-major with a fixed MAX_DIM stride regardless of active size.
  always_comb begin
    pos      = ((32'(row) * MAX_DIM) + 32'(col)) * ELEM_W + 32'(byte_idx) * 8;
    byte_out = snapshot[pos +: 8];
  end

endmodule

// File: rtl/result_sender.sv
// Streams the active d x d window of the result matrix, row-major, low byte first, to uart_tx.
// Latency: first tx_start two cycles after start is sampled; done one cycle after the last byte drains.
// Backpressure: each byte waits for tx_busy low before tx_start and for a full busy high/low cycle after.
// Ports: bclk, rst (async, active-high), bus (result_sender_if.master).
// Option: RESULT_SENDER_CHECKSUM_EN appends an XOR-of-data trailer byte before done.
module result_sender
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int ELEM_W  = matrix_pkg::ELEM_W
) (
  input logic             bclk,
  input logic             rst,
  result_sender_if.master bus
);

  localparam int BPE   = ELEM_W / 8;
  localparam int RES_W = MAX_DIM * MAX_DIM * ELEM_W;

  sender_state_t    state;
  logic [RES_W-1:0] snap;
  logic [3:0]       dim;
  logic [3:0]       row, col, bidx;
  logic [3:0]       nrow, ncol, nbidx;
  logic             last_data;
  logic [7:0]       sel_byte;
  logic [7:0]       tx_data_r;
  logic             tx_start_r, busy_r, done_r;
`ifdef RESULT_SENDER_CHECKSUM_EN
  logic [7:0]       csum;
  logic             csum_phase;
`endif

  // Position of the byte to load next: origin in LOAD, otherwise the
  // successor of the byte just sent (byte, then col, then row).
  always_comb begin
    nrow      = row;
    ncol      = col;
    nbidx     = bidx;
    last_data = 1'b0;
    if (bidx != 4'(BPE - 1)) begin
      nbidx = bidx + 4'd1;
    end else begin
      nbidx = 4'd0;
      if (col != dim - 4'd1) begin
        ncol = col + 4'd1;
      end else begin
        ncol = 4'd0;
        if (row != dim - 4'd1) nrow = row + 4'd1;
        else                   last_data = 1'b1;
      end
    end
    if (state == LOAD) begin
      nrow  = 4'd0;
      ncol  = 4'd0;
      nbidx = 4'd0;
    end
  end

  result_byte_mux #(
    .MAX_DIM (MAX_DIM),
    .ELEM_W  (ELEM_W)
  ) u_mux (
    .snapshot (snap),
    .row      (nrow),
    .col      (ncol),
    .byte_idx (nbidx),
    .byte_out (sel_byte)
  );

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      dim        <= '0;
      row        <= '0;
      col        <= '0;
      bidx       <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef RESULT_SENDER_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap   <= bus.result;
            dim    <= eff_dim(bus.size, MAX_DIM);
            busy_r <= 1'b1;
            state  <= LOAD;
`ifdef RESULT_SENDER_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        LOAD: begin
          row  <= '0;
          col  <= '0;
          bidx <= '0;
          if (dim == 4'd0) begin
`ifdef RESULT_SENDER_CHECKSUM_EN
            // Empty window still carries a (zero) trailer.
            tx_data_r  <= '0;
            csum_phase <= 1'b1;
            state      <= ISSUE;
`else
            state <= FINISH;
`endif
          end else begin
            tx_data_r <= sel_byte;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.tx_busy) begin
            tx_start_r <= 1'b1;
            state      <= WAIT_HI;
`ifdef RESULT_SENDER_CHECKSUM_EN
            if (!csum_phase) csum <= csum ^ tx_data_r;
`endif
          end
        end
        WAIT_HI: if (bus.tx_busy)  state <= WAIT_LO;
        WAIT_LO: if (!bus.tx_busy) state <= NEXT;
        NEXT: begin
`ifdef RESULT_SENDER_CHECKSUM_EN
          if (csum_phase) begin
            state <= FINISH;
          end else if (last_data) begin
            tx_data_r  <= csum;
            csum_phase <= 1'b1;
            state      <= ISSUE;
          end else begin
`else
          if (last_data) begin
            state <= FINISH;
          end else begin
`endif
            row       <= nrow;
            col       <= ncol;
            bidx      <= nbidx;
            tx_data_r <= sel_byte;
            state     <= ISSUE;
          end
        end
        FINISH: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_result_sender.sv
// Self-checking bench for result_sender: table of size/data vectors plus stall, disturb and reset sequences.
// Latency: checks first tx_start two cycles after start and done timing for an empty window.
// Backpressure: uart_tx modelled as busy for 10 cycles after each tx_start, with an optional forced-busy hold.
module tb_result_sender;

  logic bclk = 1'b0;
  logic rst;
  always #5 bclk = ~bclk;

  result_sender_if #(.MAX_DIM(3), .ELEM_W(16)) bus ();

  result_sender #(.MAX_DIM(3), .ELEM_W(16)) dut (
    .bclk (bclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // uart_tx model
  int busy_cnt   = 0;
  bit force_busy = 1'b0;
  always @(negedge bclk) begin
    if (rst)               busy_cnt = 0;
    else if (bus.tx_start) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_busy = (busy_cnt != 0) || force_busy;
  end

  // per-run observations
  int           cap_n, first_cyc, done_cyc;
  logic [151:0] cap;
  bit           timed_out, aborted;
  logic         busy_seen, abort_txs, abort_busy;

  task automatic check(input string name, input logic [151:0] got, input logic [151:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] sz, input logic [143:0] res, input int hold,
                     input int disturb, input int abort_after);
    int cyc;
    cap_n = 0; cap = '0; first_cyc = -1; done_cyc = -1;
    timed_out = 1'b0; aborted = 1'b0;
    bus.size = sz; bus.result = res; force_busy = (hold > 0);
    @(negedge bclk); bus.start = 1'b1;
    @(negedge bclk); bus.start = 1'b0; busy_seen = bus.busy;
    cyc = 0;
    while (1) begin
      @(negedge bclk); cyc++;
      if (hold > 0 && cyc == hold) force_busy = 1'b0;
      if (bus.tx_start) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (cap_n < 19) cap[cap_n*8 +: 8] = bus.tx_data;
        cap_n++;
        if (abort_after > 0 && cap_n == abort_after) begin
          rst = 1'b1;
          #1;
          abort_txs = bus.tx_start;
          abort_busy = bus.busy;
          aborted = 1'b1;
          break;
        end
      end
      if (bus.done) begin done_cyc = cyc; break; end
      if (disturb > 0 && cyc == disturb) begin
        bus.start = 1'b1; bus.size = 4'd2; bus.result = ~res;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc >= 1000) begin timed_out = 1'b1; break; end
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   sz;
    logic [143:0] res;
    int           nb;
    logic [151:0] exp;
  } vec_t;

  localparam logic [143:0] D = 144'h0808_0707_0606_0505_0404_0303_0202_0101_0000;
  localparam logic [143:0] E = 144'h9999_8888_7777_6666_5555_4444_3333_2222_1111;

  vec_t vecs[7];

  initial begin
    logic [151:0] exp;
    int           nb;
    logic [7:0]   x;
    int           extra;

    vecs[0] = '{4'd3,  D, 18, 152'(D)};
    vecs[1] = '{4'd2,  D, 8,  152'(64'h0404_0303_0101_0000)};
    vecs[2] = '{4'd0,  D, 0,  152'(0)};
    vecs[3] = '{4'd7,  D, 18, 152'(D)};
    vecs[4] = '{4'd1,  D, 2,  152'(16'h0000)};
    vecs[5] = '{4'd15, E, 18, 152'(E)};
    vecs[6] = '{4'd2,  E, 8,  152'(64'h5555_4444_2222_1111)};

    rst = 1'b1; bus.start = 1'b0; bus.size = '0; bus.result = '0;
    repeat (3) @(negedge bclk);
    check("rst_tx_data",  152'(bus.tx_data),  152'(0));
    check("rst_tx_start", 152'(bus.tx_start), 152'(0));
    check("rst_busy",     152'(bus.busy),     152'(0));
    check("rst_done",     152'(bus.done),     152'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      exp = vecs[i].exp;
      nb  = vecs[i].nb;
`ifdef RESULT_SENDER_CHECKSUM_EN
      x = 8'h00;
      for (int j = 0; j < nb; j++) x ^= exp[j*8 +: 8];
      exp[nb*8 +: 8] = x;
      nb++;
`endif
      run(vecs[i].sz, vecs[i].res, 0, 0, 0);
      check($sformatf("v%0d_timeout", i), 152'(timed_out), 152'(0));
      check($sformatf("v%0d_busy_on", i), 152'(busy_seen), 152'(1));
      check($sformatf("v%0d_nbytes", i), 152'(cap_n), 152'(nb));
      check($sformatf("v%0d_stream", i), cap, exp);
      check($sformatf("v%0d_busy_at_done", i), 152'(bus.busy), 152'(0));
      if (vecs[i].nb > 0 || nb > 0)
        check($sformatf("v%0d_first_latency", i), 152'(first_cyc), 152'(2));
`ifndef RESULT_SENDER_CHECKSUM_EN
      if (nb == 0)
        check($sformatf("v%0d_done_latency", i), 152'(done_cyc), 152'(2));
`endif
    end

    // uart_tx already busy: sender must hold off until it frees up
    run(4'd1, 144'(16'hA55A), 15, 0, 0);
    check("stall_timeout", 152'(timed_out), 152'(0));
    check("stall_first_after_hold", 152'(first_cyc >= 15), 152'(1));
    check("stall_byte0", 152'(cap[7:0]), 152'(8'h5A));
    check("stall_byte1", 152'(cap[15:8]), 152'(8'hA5));

    // second start plus result/size change mid-transfer are ignored
    run(4'd3, D, 0, 20, 0);
    check("disturb_nbytes", 152'(cap_n[7:0] >= 8'd18), 152'(1));
    check("disturb_stream", 152'(cap[143:0]), 152'(D));
    extra = 0;
    repeat (30) begin
      @(negedge bclk);
      if (bus.tx_start || bus.busy) extra++;
    end
    check("disturb_no_restart", 152'(extra), 152'(0));

    // asynchronous reset after the 5th byte
    run(4'd3, D, 0, 0, 5);
    check("abort_reached", 152'(aborted), 152'(1));
    check("abort_tx_start", 152'(abort_txs), 152'(0));
    check("abort_busy", 152'(abort_busy), 152'(0));
    @(negedge bclk); rst = 1'b0;
    run(4'd1, {128'h0, 16'hBEEF}, 0, 0, 0);
    check("post_rst_timeout", 152'(timed_out), 152'(0));
    check("post_rst_byte0", 152'(cap[7:0]), 152'(8'hEF));
    check("post_rst_byte1", 152'(cap[15:8]), 152'(8'hBE));

`ifdef RESULT_SENDER_CHECKSUM_EN
    run(4'd1, {128'h0, 16'h1234}, 0, 0, 0);
    check("csum_nbytes", 152'(cap_n), 152'(3));
    check("csum_stream", 152'(cap[23:0]), 152'(24'h26_12_34));
`else
    check("post_rst_nbytes", 152'(cap_n), 152'(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_sender.md
Name: result_sender

Overview:
- Streams the 3x3 multiplication result (nine 16-bit elements, 144 bits) out through the byte-wide uart_tx start/busy handshake.
- Sits between Calculator and uart_tx. It is the transmit-side counterpart of the RX path that fills matrix memories A and B.
- Sends only the active size x size sub-matrix, row-major, low byte first for each element.

Parameters:
- MAX_DIM, 3: maximum matrix dimension; result holds MAX_DIM*MAX_DIM elements.
- ELEM_W, 16: result element width in bits; must be a multiple of 8.

Ports:
- bclk  in  1  baud-domain clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to send the current result
- size  in  4  matrix dimension (0..15)
- result  in  MAX_DIM*MAX_DIM*ELEM_W  flat result; element k at [k*ELEM_W +: ELEM_W], k = row*MAX_DIM + col
- tx_busy  in  1  uart_tx busy flag
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle transmit request
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last byte has finished transmitting

Behaviour:
- Reset: tx_data=0, tx_start=0, busy=0, done=0. FSM goes to IDLE; all counters and snapshot registers are cleared.
- States: IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, NEXT, FINISH.
- IDLE: when start=1, snapshot result and size into internal registers, set busy=1, and go to LOAD. While not in IDLE, start is ignored.
- Effective dimension d:
  - size=0 gives d=0.
  - size>MAX_DIM clamps to d=MAX_DIM.
  - Otherwise d=size.
- LOAD: clear row, col and byte counters.
  - If d=0, go to FINISH.
  - Otherwise drive tx_data with the selected byte and go to ISSUE.
- ISSUE: hold tx_start=1 for exactly one cycle; only issued when tx_busy=0. If tx_busy=1, stay in ISSUE with tx_start=0. Then go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. tx_data stays stable throughout.
- WAIT_LO: wait for tx_busy=0, then go to NEXT.
- NEXT: advance in this order: byte index (0..ELEM_W/8-1), then col (0..d-1), then row (0..d-1).
  - If all bytes of the sub-matrix are sent, go to FINISH.
  - Otherwise load the new tx_data and go to ISSUE.
- Byte selection: element index = row*MAX_DIM + col, byte b = snapshot[(idx*ELEM_W + b*8) +: 8]. Elements outside the d x d window are never sent.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Byte count: d*d*(ELEM_W/8). With defaults, d=3 gives 18 bytes and d=2 gives 8.
- Latency: with start sampled at edge k and tx_busy=0, tx_start is high during the cycle following edge k+2.
- Changes to result or size after acceptance do not affect the transfer.
- rst mid-transfer: outputs return to reset values on the next evaluation (asynchronous). No partial done is produced, and the next start begins from byte 0.

Optional Feature:
- RESULT_SENDER_CHECKSUM_EN defined: after the last data byte, one extra byte is sent through the same ISSUE/WAIT handshake. Its value is the XOR of all data bytes sent; done follows this byte. For d=0 the checksum 0x00 is still sent.
- Undefined: no trailer byte, and no checksum register is synthesised.

Decomposition:
- Shared package (matrix_pkg):
  - MAX_DIM, ELEM_W constants.
  - Sender state encoding localparams (IDLE=0 .. FINISH=6).
  - BYTES_PER_ELEM = ELEM_W/8.
- Sub-module result_byte_mux: combinational; inputs are snapshot, row, col and byte index; output is the 8-bit byte. Separates indexing arithmetic from the FSM.

Test Plan:
- size=3, element k = 16'h0100*k + k (k=0..8), tx_busy model high for 10 cycles after each tx_start → bytes 00 00 01 01 02 02 … 08 08 (18 bytes), then done pulse, busy low.
- size=2, same data → bytes for elements 0, 1, 3, 4 only: 00 00 01 01 03 03 04 04; 8 tx_start pulses.
- size=0 → no tx_start; done two cycles after start. size=7 → identical stream to size=3.
- Second start and a change to result mid-transfer → ignored; stream matches the original snapshot.
- rst asserted after the 5th byte → tx_start=0, busy=0 immediately. A new start with size=1 and element0=16'hBEEF sends EF BE.
- RESULT_SENDER_CHECKSUM_EN, size=1, element0=16'h1234 → bytes 34 12 26, then done.
